gray_monitor: RTL and testbench

- Downstream consumer of the 3-bit Gray counter stage: samples the Gray code and sticky overflow flag every cycle.
- Converts the Gray code to binary, classifies each transition, counts completed laps, and cross-checks the counter's overflow flag.
- Latches a sticky error on any illegal transition.
- Output feeds status display and the debug/verification layer.

---
 rtl/gray_monitor_pkg.sv | 23 ++
 rtl/gray_monitor_gray2bin.sv | 23 ++
 rtl/gray_monitor.sv | 197 +++++++++++++++++++
 tb/tb_gray_monitor.sv | 351 +++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/gray_monitor_pkg.sv
// -----------------------------------------------------------------------------
// gray_monitor_pkg
// Shared constants for the Gray-code monitor slice.
//   - FSM state encoding (INIT / TRACK / FAULT)
//   - Error cause codes reported on o_errCode
// No ports; imported by gray_monitor and gray_monitor_gray2bin.
// -----------------------------------------------------------------------------
package gray_monitor_pkg;

  // Monitor FSM states. INIT only captures a first sample, TRACK classifies
  // every transition, FAULT holds until a clear or reset.
  localparam logic [1:0] ST_INIT  = 2'd0;
  localparam logic [1:0] ST_TRACK = 2'd1;
  localparam logic [1:0] ST_FAULT = 2'd2;

  // Error causes. The numeric order doubles as reporting priority when
  // several causes occur on the same edge (MULTI wins over BACK over OVF).
  localparam logic [1:0] ERR_NONE  = 2'b00;
  localparam logic [1:0] ERR_MULTI = 2'b01;
  localparam logic [1:0] ERR_BACK  = 2'b10;
  localparam logic [1:0] ERR_OVF   = 2'b11;

endpackage

// File: rtl/gray_monitor_gray2bin.sv
// -----------------------------------------------------------------------------
// gray_monitor_gray2bin
// Purely combinational Gray-to-binary converter.
// Ports:
//   i_gray  [WIDTH-1:0]  Gray-coded input
//   o_bin   [WIDTH-1:0]  binary equivalent
// -----------------------------------------------------------------------------
module gray_monitor_gray2bin
  import gray_monitor_pkg::*;
#(
  parameter int WIDTH = 3
) (
  input  logic [WIDTH-1:0] i_gray,
  output logic [WIDTH-1:0] o_bin
);

  // Each binary bit is the XOR of all Gray bits at or above it. Writing it as
  // a reduction over a slice avoids a self-referencing ripple on o_bin.
  for (genvar i = 0; i < WIDTH; i++) begin : g_bit
    assign o_bin[i] = ^i_gray[WIDTH-1:i];
  end

endmodule

// File: rtl/gray_monitor.sv
// -----------------------------------------------------------------------------
// gray_monitor
// Consumer of an upstream Gray counter. Samples the Gray code and the
// upstream sticky overflow flag every cycle, converts to binary, classifies
// each transition, counts completed laps and latches the first error cause.
// Ports:
//   i_clk      clock, all state changes on posedge
//   i_rst      asynchronous active-high reset
//   i_clr      synchronous clear of fault/laps, returns FSM to INIT
//   i_gray     [WIDTH-1:0] Gray code from upstream counter
//   i_ovfIn    upstream sticky overflow flag
//   o_bin      [WIDTH-1:0] registered binary of the last sampled Gray code
//   o_step     one-cycle pulse on a legal single-step advance
//   o_wrap     one-cycle pulse on a forward max->0 step
//   o_laps     [LAP_W-1:0] saturating count of completed forward laps
//   o_err      sticky error flag
//   o_errCode  [1:0] first error cause (see gray_monitor_pkg)
// -----------------------------------------------------------------------------
module gray_monitor
  import gray_monitor_pkg::*;
#(
  parameter int WIDTH      = 3,
  parameter int LAP_W      = 8,
  parameter bit ALLOW_BACK = 1'b0
) (
  input  logic             i_clk,
  input  logic             i_rst,
  input  logic             i_clr,
  input  logic [WIDTH-1:0] i_gray,
  input  logic             i_ovfIn,
  output logic [WIDTH-1:0] o_bin,
  output logic             o_step,
  output logic             o_wrap,
  output logic [LAP_W-1:0] o_laps,
  output logic             o_err,
  output logic [1:0]       o_errCode
);

  localparam logic [WIDTH-1:0] BinMax = '1;
  localparam logic [WIDTH-1:0] BinOne = WIDTH'(1);
  localparam logic [LAP_W-1:0] LapMax = '1;
  localparam logic [LAP_W-1:0] LapOne = LAP_W'(1);

  // Registered state
  logic [1:0]       r_state;
  logic [WIDTH-1:0] r_prevGray;
  logic             r_prevOvf;
  logic [WIDTH-1:0] r_bin;
  logic             r_step;
  logic             r_wrap;
  logic [LAP_W-1:0] r_laps;
  logic             r_err;
  logic [1:0]       r_errCode;

  // Conversion and classification
  logic [WIDTH-1:0] w_curBin;
  logic [WIDTH-1:0] w_prevBin;
  logic             w_same;
  logic             w_fwd;
  logic             w_back;
  logic             w_multi;
  logic             w_fwdWrap;
  logic             w_backWrap;
  logic             w_ovfRise;
  logic             w_ovfErr;

  // Next-state values
  logic [1:0]       w_nextState;
  logic             w_nextStep;
  logic             w_nextWrap;
  logic [LAP_W-1:0] w_nextLaps;
  logic             w_nextErr;
  logic [1:0]       w_nextErrCode;

  gray_monitor_gray2bin #(.WIDTH(WIDTH)) u_curConv (
    .i_gray (i_gray),
    .o_bin  (w_curBin)
  );

  gray_monitor_gray2bin #(.WIDTH(WIDTH)) u_prevConv (
    .i_gray (r_prevGray),
    .o_bin  (w_prevBin)
  );

  // Transition classes, all mod 2^WIDTH through natural wraparound of the
  // WIDTH-bit adders. Anything that is neither a hold nor a +/-1 step is
  // treated as a multi-bit jump: this covers every Hamming distance > 1 and
  // also the single-bit Gray changes that are not adjacent in binary.
  assign w_same     = (i_gray == r_prevGray);
  assign w_fwd      = (w_curBin == (w_prevBin + BinOne));
  assign w_back     = (w_curBin == (w_prevBin - BinOne));
  assign w_multi    = !w_same && !w_fwd && !w_back;
  assign w_fwdWrap  = w_fwd  && (w_prevBin == BinMax) && (w_curBin == '0);
  assign w_backWrap = w_back && (w_prevBin == '0) && (w_curBin == BinMax);

  // The upstream flag is sticky, so only its rising edge is meaningful and it
  // must coincide with a forward wrap. A falling edge is never an error.
  assign w_ovfRise  = !r_prevOvf && i_ovfIn;
  assign w_ovfErr   = w_ovfRise && !w_fwdWrap;

  // FSM and datapath next-state. Clear beats classification; inside TRACK the
  // error checks are ordered by reporting priority and any error suppresses
  // the Step/Wrap pulses and lap update for that edge.
  always_comb begin
    w_nextState   = r_state;
    w_nextStep    = 1'b0;
    w_nextWrap    = 1'b0;
    w_nextLaps    = r_laps;
    w_nextErr     = r_err;
    w_nextErrCode = r_errCode;

    if (i_clr) begin
      w_nextState   = ST_INIT;
      w_nextLaps    = '0;
      w_nextErr     = 1'b0;
      w_nextErrCode = ERR_NONE;
    end else begin
      case (r_state)
        ST_INIT: begin
          w_nextState = ST_TRACK;
        end

        ST_TRACK: begin
          if (w_multi) begin
            w_nextState   = ST_FAULT;
            w_nextErr     = 1'b1;
            w_nextErrCode = ERR_MULTI;
          end else if (w_back && !ALLOW_BACK) begin
            w_nextState   = ST_FAULT;
            w_nextErr     = 1'b1;
            w_nextErrCode = ERR_BACK;
          end else if (w_ovfErr) begin
            w_nextState   = ST_FAULT;
            w_nextErr     = 1'b1;
            w_nextErrCode = ERR_OVF;
          end else if (w_fwd) begin
            w_nextStep = 1'b1;
            if (w_fwdWrap) begin
              w_nextWrap = 1'b1;
              if (r_laps != LapMax) begin
                w_nextLaps = r_laps + LapOne;
              end
            end
          end else if (w_back) begin
            w_nextStep = 1'b1;
            if (w_backWrap && (r_laps != '0)) begin
              w_nextLaps = r_laps - LapOne;
            end
          end
        end

        ST_FAULT: begin
          w_nextState = ST_FAULT;
        end

        default: begin
          w_nextState = ST_INIT;
        end
      endcase
    end
  end

  // State registers. Bin and the previous-sample registers update on every
  // edge regardless of FSM state or clear, so the display keeps tracking
  // even while faulted and a clear re-arms against the current sample.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_state    <= ST_INIT;
      r_prevGray <= '0;
      r_prevOvf  <= 1'b0;
      r_bin      <= '0;
      r_step     <= 1'b0;
      r_wrap     <= 1'b0;
      r_laps     <= '0;
      r_err      <= 1'b0;
      r_errCode  <= ERR_NONE;
    end else begin
      r_state    <= w_nextState;
      r_prevGray <= i_gray;
      r_prevOvf  <= i_ovfIn;
      r_bin      <= w_curBin;
      r_step     <= w_nextStep;
      r_wrap     <= w_nextWrap;
      r_laps     <= w_nextLaps;
      r_err      <= w_nextErr;
      r_errCode  <= w_nextErrCode;
    end
  end

  assign o_bin     = r_bin;
  assign o_step    = r_step;
  assign o_wrap    = r_wrap;
  assign o_laps    = r_laps;
  assign o_err     = r_err;
  assign o_errCode = r_errCode;

endmodule

// File: tb/tb_gray_monitor.sv
// -----------------------------------------------------------------------------
// tb_gray_monitor
// Drives two monitors in parallel from the same inputs: uA rejects backward
// steps, uB accepts them. A behavioural reference model predicts each edge;
// predictions are queued when stimulus is driven and compared after the edge.
// -----------------------------------------------------------------------------
module tb_gray_monitor;

  logic       clk = 1'b0;
  logic       rst;
  logic       clr;
  logic [2:0] gray;
  logic       ovf;

  logic [2:0] binA, binB;
  logic       stepA, stepB, wrapA, wrapB;
  logic [7:0] lapsA, lapsB;
  logic       errA, errB;
  logic [1:0] codeA, codeB;

  int total = 0;
  int bad   = 0;

  typedef struct packed {
    logic [2:0] bin;
    logic       step;
    logic       wrap;
    logic [7:0] laps;
    logic       err;
    logic [1:0] code;
  } expT;

  typedef struct packed {
    expT a;
    expT b;
  } expPairT;

  expPairT sbQueue[$];

  // Reference model state, index 0 = uA (no backward), 1 = uB (backward ok)
  int mState[2];
  int mPrevG[2];
  int mPrevOvf[2];
  int mBin[2];
  int mStep[2];
  int mWrap[2];
  int mLaps[2];
  int mErr[2];
  int mCode[2];

  logic [2:0] fwdSeq [8] = '{3'b001, 3'b011, 3'b010, 3'b110,
                             3'b111, 3'b101, 3'b100, 3'b000};

  gray_monitor #(.WIDTH(3), .LAP_W(8), .ALLOW_BACK(1'b0)) uA (
    .i_clk     (clk),
    .i_rst     (rst),
    .i_clr     (clr),
    .i_gray    (gray),
    .i_ovfIn   (ovf),
    .o_bin     (binA),
    .o_step    (stepA),
    .o_wrap    (wrapA),
    .o_laps    (lapsA),
    .o_err     (errA),
    .o_errCode (codeA)
  );

  gray_monitor #(.WIDTH(3), .LAP_W(8), .ALLOW_BACK(1'b1)) uB (
    .i_clk     (clk),
    .i_rst     (rst),
    .i_clr     (clr),
    .i_gray    (gray),
    .i_ovfIn   (ovf),
    .o_bin     (binB),
    .o_step    (stepB),
    .o_wrap    (wrapB),
    .o_laps    (lapsB),
    .o_err     (errB),
    .o_errCode (codeB)
  );

  // Free-running clock, posedges at 5, 15, 25, ...
  initial begin
    forever #5 clk = ~clk;
  end

  // Safety net so a stuck run still ends with a visible failure.
  initial begin
    #400000;
    $display("[TB] FAIL watchdog observed=timeout expected=finish total=%0d bad=%0d", total, bad + 1);
    $fatal(1, "[TB] watchdog expired");
  end

  // Gray to binary by shifting XOR, independent of the RTL slice form.
  function automatic int g2b(input int g);
    int b;
    int s;
    b = g;
    s = g >> 1;
    while (s != 0) begin
      b = b ^ s;
      s = s >> 1;
    end
    return b;
  endfunction

  // Resets the behavioural model to its power-on state.
  task automatic modelReset();
    for (int d = 0; d < 2; d++) begin
      mState[d]   = 0;
      mPrevG[d]   = 0;
      mPrevOvf[d] = 0;
      mBin[d]     = 0;
      mStep[d]    = 0;
      mWrap[d]    = 0;
      mLaps[d]    = 0;
      mErr[d]     = 0;
      mCode[d]    = 0;
    end
    sbQueue.delete();
  endtask

  // Advances the model by one clock edge. States: 0 INIT, 1 TRACK, 2 FAULT.
  task automatic modelEdge(input int d, input int g, input int o, input int c);
    int  pb;
    int  nb;
    bit  fwd;
    bit  back;
    bit  same;
    bit  multi;
    bit  ovfBad;
    bit  allow;
    allow  = (d == 1);
    pb     = g2b(mPrevG[d]);
    nb     = g2b(g);
    same   = (g == mPrevG[d]);
    fwd    = (nb == ((pb + 1) % 8));
    back   = (nb == ((pb + 7) % 8));
    multi  = !same && !fwd && !back;
    ovfBad = (mPrevOvf[d] == 0) && (o == 1) && !(fwd && pb == 7 && nb == 0);
    mStep[d] = 0;
    mWrap[d] = 0;
    if (c != 0) begin
      mState[d] = 0;
      mLaps[d]  = 0;
      mErr[d]   = 0;
      mCode[d]  = 0;
    end else if (mState[d] == 0) begin
      mState[d] = 1;
    end else if (mState[d] == 1) begin
      if (multi) begin
        mState[d] = 2; mErr[d] = 1; mCode[d] = 1;
      end else if (back && !allow) begin
        mState[d] = 2; mErr[d] = 1; mCode[d] = 2;
      end else if (ovfBad) begin
        mState[d] = 2; mErr[d] = 1; mCode[d] = 3;
      end else if (fwd) begin
        mStep[d] = 1;
        if (pb == 7 && nb == 0) begin
          mWrap[d] = 1;
          if (mLaps[d] < 255) mLaps[d] = mLaps[d] + 1;
        end
      end else if (back) begin
        mStep[d] = 1;
        if (pb == 0 && nb == 7 && mLaps[d] > 0) mLaps[d] = mLaps[d] - 1;
      end
    end
    mBin[d]     = nb;
    mPrevG[d]   = g;
    mPrevOvf[d] = o;
  endtask

  function automatic expT packModel(input int d);
    expT e;
    e.bin  = 3'(mBin[d]);
    e.step = mStep[d][0];
    e.wrap = mWrap[d][0];
    e.laps = 8'(mLaps[d]);
    e.err  = mErr[d][0];
    e.code = 2'(mCode[d]);
    return e;
  endfunction

  // Single comparison point; every check in the bench goes through here.
  task automatic checkVal(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("[TB] FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Pops the oldest prediction and compares both monitors against it.
  task automatic checkOutput();
    expPairT e;
    total++;
    assert (sbQueue.size() > 0) else begin
      bad++;
      $error("[TB] FAIL scoreboard observed=empty expected=entry");
    end
    if (sbQueue.size() > 0) begin
      e = sbQueue.pop_front();
      checkVal("A.bin",  32'(binA),  32'(e.a.bin));
      checkVal("A.step", 32'(stepA), 32'(e.a.step));
      checkVal("A.wrap", 32'(wrapA), 32'(e.a.wrap));
      checkVal("A.laps", 32'(lapsA), 32'(e.a.laps));
      checkVal("A.err",  32'(errA),  32'(e.a.err));
      checkVal("A.code", 32'(codeA), 32'(e.a.code));
      checkVal("B.bin",  32'(binB),  32'(e.b.bin));
      checkVal("B.step", 32'(stepB), 32'(e.b.step));
      checkVal("B.wrap", 32'(wrapB), 32'(e.b.wrap));
      checkVal("B.laps", 32'(lapsB), 32'(e.b.laps));
      checkVal("B.err",  32'(errB),  32'(e.b.err));
      checkVal("B.code", 32'(codeB), 32'(e.b.code));
    end
  endtask

  // Drives one sample on the falling edge, queues the prediction, then
  // checks just after the following rising edge.
  task automatic applyStimulus(input logic [2:0] g, input logic o, input logic c);
    expPairT p;
    @(negedge clk);
    gray = g;
    ovf  = o;
    clr  = c;
    modelEdge(0, int'(g), int'(o), int'(c));
    modelEdge(1, int'(g), int'(o), int'(c));
    p.a = packModel(0);
    p.b = packModel(1);
    sbQueue.push_back(p);
    @(posedge clk);
    #1;
    checkOutput();
  endtask

  // All outputs of both monitors must read zero while reset is applied.
  task automatic checkReset(input string tag);
    checkVal({tag, ".A.bin"},  32'(binA),  0);
    checkVal({tag, ".A.step"}, 32'(stepA), 0);
    checkVal({tag, ".A.wrap"}, 32'(wrapA), 0);
    checkVal({tag, ".A.laps"}, 32'(lapsA), 0);
    checkVal({tag, ".A.err"},  32'(errA),  0);
    checkVal({tag, ".A.code"}, 32'(codeA), 0);
    checkVal({tag, ".B.bin"},  32'(binB),  0);
    checkVal({tag, ".B.laps"}, 32'(lapsB), 0);
    checkVal({tag, ".B.err"},  32'(errB),  0);
  endtask

  initial begin
    rst  = 1'b1;
    clr  = 1'b0;
    gray = 3'b000;
    ovf  = 1'b0;
    modelReset();
    #3;
    checkReset("por");
    @(posedge clk);
    #2;
    rst = 1'b0;

    // One full forward lap, overflow rising together with the wrap.
    $display("[TB] forward lap");
    applyStimulus(3'b000, 1'b0, 1'b0);
    for (int i = 0; i < 7; i++) applyStimulus(fwdSeq[i], 1'b0, 1'b0);
    applyStimulus(3'b000, 1'b1, 1'b0);
    checkVal("lap1.laps", 32'(lapsA), 1);
    checkVal("lap1.wrap", 32'(wrapA), 1);
    checkVal("lap1.err",  32'(errA),  0);

    // Multi-bit jump 001 -> 010, then tracking while faulted.
    $display("[TB] multi-bit jump");
    applyStimulus(3'b001, 1'b1, 1'b0);
    applyStimulus(3'b010, 1'b1, 1'b0);
    checkVal("multi.code", 32'(codeA), 1);
    checkVal("multi.step", 32'(stepA), 0);
    applyStimulus(3'b011, 1'b1, 1'b0);
    checkVal("multi.bin",  32'(binA),  2);
    checkVal("multi.laps", 32'(lapsA), 1);

    // Backward 011 -> 001: error on uA, legal step on uB.
    $display("[TB] backward step");
    applyStimulus(3'b011, 1'b1, 1'b1);
    applyStimulus(3'b011, 1'b1, 1'b0);
    applyStimulus(3'b001, 1'b1, 1'b0);
    checkVal("back.A.code", 32'(codeA), 2);
    checkVal("back.B.step", 32'(stepB), 1);
    checkVal("back.B.err",  32'(errB),  0);

    // Backward wraps on uB: lap count goes down and saturates at zero.
    $display("[TB] backward wrap");
    applyStimulus(3'b000, 1'b0, 1'b1);
    applyStimulus(3'b000, 1'b0, 1'b0);
    for (int i = 0; i < 8; i++) applyStimulus(fwdSeq[i], 1'b0, 1'b0);
    applyStimulus(3'b100, 1'b0, 1'b0);
    checkVal("bwrap.B.laps", 32'(lapsB), 0);
    applyStimulus(3'b000, 1'b0, 1'b0);
    applyStimulus(3'b100, 1'b0, 1'b0);
    for (int i = 6; i >= 0; i--) applyStimulus((i == 0) ? 3'b000 : fwdSeq[i - 1], 1'b0, 1'b0);
    applyStimulus(3'b100, 1'b0, 1'b0);
    checkVal("bwrap.sat.B.laps", 32'(lapsB), 0);

    // Overflow rising on a plain step 010 -> 110, then clear.
    $display("[TB] overflow mismatch");
    applyStimulus(3'b010, 1'b0, 1'b1);
    applyStimulus(3'b010, 1'b0, 1'b0);
    applyStimulus(3'b110, 1'b1, 1'b0);
    checkVal("ovf.A.code", 32'(codeA), 3);
    checkVal("ovf.B.err",  32'(errB),  1);
    applyStimulus(3'b110, 1'b1, 1'b1);
    checkVal("clr.A.err",  32'(errA),  0);
    applyStimulus(3'b111, 1'b1, 1'b0);
    checkVal("clr.A.step", 32'(stepA), 0);

    // Lap counter saturation and per-lap wrap pulses.
    $display("[TB] lap saturation");
    applyStimulus(3'b101, 1'b1, 1'b0);
    applyStimulus(3'b100, 1'b1, 1'b0);
    applyStimulus(3'b000, 1'b1, 1'b0);
    for (int lap = 0; lap < 300; lap++) begin
      for (int i = 0; i < 8; i++) applyStimulus(fwdSeq[i], 1'b1, 1'b0);
    end
    checkVal("sat.A.laps", 32'(lapsA), 255);
    checkVal("sat.B.laps", 32'(lapsB), 255);
    checkVal("sat.A.wrap", 32'(wrapA), 1);

    // Gray held for several cycles: no pulses.
    $display("[TB] hold");
    for (int i = 0; i < 5; i++) applyStimulus(3'b000, 1'b1, 1'b0);
    checkVal("hold.A.step", 32'(stepA), 0);

    // Asynchronous reset between edges, then restart from a nonzero code.
    $display("[TB] async reset");
    applyStimulus(3'b001, 1'b1, 1'b0);
    #1;
    rst = 1'b1;
    #1;
    checkReset("async");
    modelReset();
    gray = 3'b110;
    #1;
    rst = 1'b0;
    applyStimulus(3'b110, 1'b1, 1'b0);
    checkVal("post.A.err", 32'(errA), 0);
    applyStimulus(3'b111, 1'b1, 1'b0);
    checkVal("post.A.step", 32'(stepA), 1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
